spi_master_mc: RTL and testbench



---
 rtl/spi_pkg.sv | 46 ++++
 rtl/spi_shift_engine.sv | 166 ++++++++++++++++
 rtl/spi_master_mc.sv | 178 +++++++++++++++++
 tb/tb_spi_master_mc.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the multi-slave SPI master:
//   - register offsets within the 4-byte register block
//   - STATUS and CTRL bit positions
//   - shift-engine FSM state encoding
//   - bit-order helper used by the shift engine
// ---------------------------------------------------------------------------
package spi_pkg;

    // Register offsets (addr[1:0])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_BUSY     = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_RX_VALID = 3;
    localparam int ST_RX_OVR   = 4;

    // CTRL bit positions
    localparam int CTRL_CPOL  = 0;
    localparam int CTRL_CPHA  = 1;
    localparam int CTRL_LSB   = 2;
    localparam int CTRL_SS_LO = 4;
    localparam int CTRL_SS_HI = 6;

    // Writable CTRL bits; bits 3 and 7 always read 0
    localparam logic [7:0] CTRL_MASK = 8'h77;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } spi_state_e;

    // Position in the byte of the j-th transmitted bit (j = 0 goes first).
    function automatic logic [2:0] bit_pos(input logic [2:0] j, input logic lsb_first);
        return lsb_first ? j : 3'd7 - j;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// ---------------------------------------------------------------------------
// spi_shift_engine
// Serialises one byte at a time on sclk/mosi while capturing miso.
// Sequence per byte: SETUP (1 half-period, ss asserted) -> SHIFT (16 sclk
// edges, one per half-period) -> GAP (1 half-period, byte reported).
// Configuration is latched when a byte is loaded.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             a byte is waiting in tx_byte
//   tx_byte           byte to transmit
//   cpol, cpha        SPI mode
//   lsb_first         bit order
//   div               half-period = div+1 clk cycles
//   ss_idx            slave index; >= NUM_SS selects no slave
//   miso              serial input (already synchronised)
//   done              one-cycle strobe: rx_byte holds the received byte
//   rx_byte           received byte
//   busy              a byte is in flight
//   req_next          tx_byte is consumed on this clock edge
//   sclk, mosi, ss_n  registered SPI outputs
// ---------------------------------------------------------------------------
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int NUM_SS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        tx_byte,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [7:0]        div,
    input  logic [2:0]        ss_idx,
    input  logic              miso,
    output logic              done,
    output logic [7:0]        rx_byte,
    output logic              busy,
    output logic              req_next,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n
);

    spi_state_e        state_q;
    logic [7:0]        cnt_q;
    logic [7:0]        div_q;
    logic [7:0]        tx_q;
    logic [7:0]        rx_q;
    logic [3:0]        edge_q;     // sclk edges already issued in this byte
    logic              cpha_q;
    logic              lsb_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              busy_q;
    logic [NUM_SS-1:0] ss_n_q;

    logic [NUM_SS-1:0] ss_dec;
    logic              half_end;
    logic              load;
    logic              sample_edge;
    logic [2:0]        shift_idx;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_idx == i[2:0]) ss_dec[i] = 1'b0;
        end
    end

    assign half_end    = (cnt_q == div_q);
    // A byte is taken from IDLE, or at the end of GAP for back-to-back bytes.
    assign load        = start && ((state_q == S_IDLE) || (state_q == S_GAP && half_end));
    // Edge n (1-based) is edge_q+1: odd edges are leading. CPHA=0 samples on
    // leading edges, CPHA=1 on trailing ones.
    assign sample_edge = (edge_q[0] == cpha_q);
    // Order index of the bit presented on this shift edge. With CPHA=0 bit 0
    // was already presented in SETUP, so trailing edge 2k presents bit k.
    assign shift_idx   = cpha_q ? edge_q[3:1] : edge_q[3:1] + 3'd1;

    assign done     = (state_q == S_GAP) && half_end;
    assign rx_byte  = rx_q;
    assign busy     = busy_q;
    assign req_next = load;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            edge_q  <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            ss_n_q  <= '1;
        end else if (load) begin
            state_q <= S_SETUP;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= tx_byte;
            rx_q    <= '0;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            div_q   <= div;
            ss_n_q  <= ss_dec;
            busy_q  <= 1'b1;
            sclk_q  <= cpol;
            if (!cpha) mosi_q <= tx_byte[bit_pos(3'd0, lsb_first)];
        end else begin
            case (state_q)
                S_IDLE: begin
                    sclk_q <= cpol;
                    ss_n_q <= '1;
                end
                S_SETUP: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (half_end) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 4'd1;
                        if (sample_edge) begin
                            rx_q <= lsb_q ? {miso, rx_q[7:1]} : {rx_q[6:0], miso};
                        end else if (cpha_q || edge_q != 4'd15) begin
                            mosi_q <= tx_q[bit_pos(shift_idx, lsb_q)];
                        end
                        if (edge_q == 4'd15) state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        ss_n_q  <= '1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// ---------------------------------------------------------------------------
// spi_master_mc
// Memory-mapped SPI master on the 8-bit CPU I/O bus.
// Register block at BASE_ADDR (addr[7:2] match), index addr[1:0]:
//   0 DATA   W: load TX buffer     R: rx_data, clears rx_valid
//   1 STATUS R: {rx_ovr,rx_valid,tx_ovf,tx_full,busy}  W1C: bit2, bit4
//   2 DIV    half-period = DIV+1 clk cycles (ignored while busy)
//   3 CTRL   {ss_idx[6:4], lsb_first[2], cpha[1], cpol[0]} (ignored while busy)
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   addr, din      CPU address / write data
//   wr_en, rd_en   one-cycle access strobes
//   dout           registered read data, 8'h00 when not reading
//   sclk, mosi     SPI clock / data out
//   miso           SPI data in (synchronised by the caller)
//   ss_n           active-low slave selects
// ---------------------------------------------------------------------------
module spi_master_mc
    import spi_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h80,
    parameter int         NUM_SS    = 4,
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    logic [7:0] tx_buf_q,  tx_buf_d;
    logic       tx_full_q, tx_full_d;
    logic       tx_ovf_q,  tx_ovf_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ovr_q,  rx_ovr_d;
    logic [7:0] div_q,     div_d;
    logic [7:0] ctrl_q,    ctrl_d;
    logic [7:0] dout_q,    dout_d;

    logic       hit;
    logic       wr_hit;
    logic       rd_hit;
    logic [1:0] idx;
    logic       rd_data;
    logic [7:0] status;

    logic       eng_done;
    logic [7:0] eng_rx;
    logic       eng_busy;
    logic       eng_req;

    spi_shift_engine #(
        .NUM_SS (NUM_SS)
    ) u_engine (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (tx_full_q),
        .tx_byte   (tx_buf_q),
        .cpol      (ctrl_q[CTRL_CPOL]),
        .cpha      (ctrl_q[CTRL_CPHA]),
        .lsb_first (ctrl_q[CTRL_LSB]),
        .div       (div_q),
        .ss_idx    (ctrl_q[CTRL_SS_HI:CTRL_SS_LO]),
        .miso      (miso),
        .done      (eng_done),
        .rx_byte   (eng_rx),
        .busy      (eng_busy),
        .req_next  (eng_req),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss_n      (ss_n)
    );

    assign hit     = (addr[7:2] == BASE_ADDR[7:2]);
    assign idx     = addr[1:0];
    assign wr_hit  = wr_en && hit;
    assign rd_hit  = rd_en && hit;
    assign rd_data = rd_hit && (idx == REG_DATA);

    always_comb begin
        status              = '0;
        status[ST_BUSY]     = eng_busy;
        status[ST_TX_FULL]  = tx_full_q;
        status[ST_TX_OVF]   = tx_ovf_q;
        status[ST_RX_VALID] = rx_valid_q;
        status[ST_RX_OVR]   = rx_ovr_q;
    end

    always_comb begin
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        tx_ovf_d   = tx_ovf_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        div_d      = div_q;
        ctrl_d     = ctrl_q;
        dout_d     = 8'h00;

        // Flag clears come first so a same-cycle set below overrides them.
        if (wr_hit && idx == REG_STATUS) begin
            if (din[ST_TX_OVF]) tx_ovf_d = 1'b0;
            if (din[ST_RX_OVR]) rx_ovr_d = 1'b0;
        end

        if (eng_req) tx_full_d = 1'b0;

        // A write landing on the cycle the engine takes the buffer is accepted.
        if (wr_hit && idx == REG_DATA) begin
            if (tx_full_q && !eng_req) begin
                tx_ovf_d = 1'b1;
            end else begin
                tx_buf_d  = din;
                tx_full_d = 1'b1;
            end
        end

        if (rd_data) rx_valid_d = 1'b0;

        // New byte beats a concurrent DATA read; that read still returns the
        // old byte and does not count as an overrun.
        if (eng_done) begin
            rx_data_d  = eng_rx;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_data) rx_ovr_d = 1'b1;
        end

        if (wr_hit && !eng_busy) begin
            if (idx == REG_DIV)  div_d  = din;
            if (idx == REG_CTRL) ctrl_d = din & CTRL_MASK;
        end

        if (rd_hit) begin
            case (idx)
                REG_DATA:   dout_d = rx_data_q;
                REG_STATUS: dout_d = status;
                REG_DIV:    dout_d = div_q;
                default:    dout_d = ctrl_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            div_q      <= DIV_RESET;
            ctrl_q     <= '0;
            dout_q     <= '0;
        end else begin
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            dout_q     <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// ---------------------------------------------------------------------------
// tb_spi_master_mc
// Directed and randomised checks of spi_master_mc. A protocol monitor
// records mosi at the sample edges implied by the SPI mode, counts sclk
// edges and half-period lengths, and measures how long ss_n is asserted.
// Expected values come from the SPI rules: bit order, 18*(DIV+1) byte time,
// loopback (miso = mosi) returning the transmitted byte, register semantics.
// ---------------------------------------------------------------------------
module tb_spi_master_mc;

    localparam int NUM_SS = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        addr = 8'h00;
    logic [7:0]        din = 8'h00;
    logic [7:0]        dout;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;

    logic loop_en  = 1'b0;
    logic miso_drv = 1'b0;
    assign miso = loop_en ? mosi : miso_drv;

    int checks   = 0;
    int failures = 0;

    spi_master_mc #(
        .BASE_ADDR (8'h80),
        .NUM_SS    (NUM_SS),
        .DIV_RESET (8'd3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .ss_n    (ss_n)
    );

    always #5 clk = ~clk;

    // ---------------- protocol monitor ----------------
    bit                mon_clr = 1'b0;
    bit                tb_cpha = 1'b0;
    int                mon_edges = 0;
    int                ss_low_cycles = 0;
    int                ss_rises = 0;
    int                iv_min = 0;
    int                iv_max = 0;
    int                cyc = 0;
    int                last_chg = -1;
    logic              prev_sclk = 1'b0;
    logic [NUM_SS-1:0] prev_ss = '1;
    logic              mon_bits[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_clr) begin
                mon_edges     = 0;
                ss_low_cycles = 0;
                ss_rises      = 0;
                iv_min        = 1000000;
                iv_max        = 0;
                last_chg      = -1;
                mon_bits.delete();
            end else begin
                if (ss_n != '1) ss_low_cycles++;
                if (prev_ss != '1 && ss_n == '1) ss_rises++;
                if (sclk !== prev_sclk) begin
                    mon_edges++;
                    if (last_chg >= 0) begin
                        if (cyc - last_chg < iv_min) iv_min = cyc - last_chg;
                        if (cyc - last_chg > iv_max) iv_max = cyc - last_chg;
                    end
                    last_chg = cyc;
                    // Odd edges lead; CPHA=0 samples on them, CPHA=1 on trailing.
                    if ((mon_edges % 2 == 1) != tb_cpha) mon_bits.push_back(mosi);
                end
            end
            prev_sclk = sclk;
            prev_ss   = ss_n;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        din   = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d     = dout;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic mon_reset();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    // Polls STATUS until neither busy nor tx_full, bounded.
    task automatic wait_idle(input string tag);
        logic [7:0] s;
        int n;
        n = 0;
        do begin
            rd(8'h81, s);
            n++;
        end while (s[1:0] != 2'b00 && n < 400);
        check(tag, s[1:0], 2'b00);
    endtask

    // Order in which the bits of b appear on the wire, first bit at [7].
    function automatic logic [7:0] wire_order(input logic [7:0] b, input logic lsb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = lsb ? b[i] : b[7-i];
        return r;
    endfunction

    function automatic logic [7:0] mon_seq(input int first);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++)
            if (first + i < mon_bits.size()) r[7-i] = mon_bits[first+i];
            else r[7-i] = 1'bx;
        return r;
    endfunction

    function automatic logic [NUM_SS-1:0] exp_ss(input int ss_index);
        logic [NUM_SS-1:0] r;
        r = '1;
        if (ss_index < NUM_SS) r[ss_index] = 1'b0;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        logic [7:0] rb;
        logic [7:0] rctrl;
        int         rdiv;
        int         rss;
        int         n;

        // Reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ss_n", ss_n, 4'hF);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        rd_check("rst_status", 8'h81, 8'h00);
        rd_check("rst_div", 8'h82, 8'h03);
        @(negedge clk);
        check("dout_idle_zero", dout, 8'h00);
        rd_check("rst_ctrl", 8'h83, 8'h00);
        rd_check("miss_read", 8'h41, 8'h00);

        // Mode 0, DIV=1, loopback, 0xA5
        wr(8'h82, 8'h01);
        wr(8'h83, 8'h00);
        tb_cpha = 1'b0;
        loop_en = 1'b1;
        mon_reset();
        wr(8'h80, 8'hA5);
        @(negedge clk);
        check("m0_ss_n", ss_n, 4'hE);
        wr(8'h82, 8'h07);               // busy: ignored
        wr(8'h83, 8'h01);               // busy: ignored
        wait_idle("m0_idle");
        check("m0_edges", mon_edges, 16);
        check("m0_half_min", iv_min, 2);
        check("m0_half_max", iv_max, 2);
        check("m0_byte_time", ss_low_cycles, 36);
        check("m0_mosi_seq", mon_seq(0), 8'hA5);
        rd_check("m0_status", 8'h81, 8'h08);
        rd_check("m0_data", 8'h80, 8'hA5);
        @(negedge clk);
        check("m0_dout_after_read", dout, 8'h00);
        rd_check("m0_status_clr", 8'h81, 8'h00);
        rd_check("m0_div_kept", 8'h82, 8'h01);
        rd_check("m0_ctrl_kept", 8'h83, 8'h00);

        // Mode 3, ss1, miso held 1
        wr(8'h83, 8'h13);
        tb_cpha  = 1'b1;
        loop_en  = 1'b0;
        miso_drv = 1'b1;
        repeat (2) @(negedge clk);
        check("m3_sclk_idle", sclk, 1'b1);
        mon_reset();
        wr(8'h80, 8'h3C);
        @(negedge clk);
        check("m3_ss_n", ss_n, 4'hD);
        wait_idle("m3_idle");
        check("m3_mosi_seq", mon_seq(0), 8'h3C);
        check("m3_sclk_end", sclk, 1'b1);
        rd_check("m3_data", 8'h80, 8'hFF);

        // LSB-first, 0x01
        wr(8'h83, 8'h04);
        tb_cpha = 1'b0;
        loop_en = 1'b1;
        mon_reset();
        wr(8'h80, 8'h01);
        wait_idle("lsb_idle");
        check("lsb_mosi_seq", mon_seq(0), 8'h80);
        rd_check("lsb_data", 8'h80, 8'h01);

        // Back-to-back with one dropped write, DIV=0
        wr(8'h82, 8'h00);
        wr(8'h83, 8'h00);
        mon_reset();
        wr(8'h80, 8'h11);
        wr(8'h80, 8'h22);
        wr(8'h80, 8'h33);
        wait_idle("b2b_idle");
        check("b2b_ss_rises", ss_rises, 1);
        check("b2b_ss_low", ss_low_cycles, 36);
        check("b2b_edges", mon_edges, 32);
        check("b2b_seq0", mon_seq(0), 8'h11);
        check("b2b_seq1", mon_seq(8), 8'h22);
        rd_check("b2b_status", 8'h81, 8'h1C);
        rd_check("b2b_data", 8'h80, 8'h22);
        wr(8'h81, 8'h14);
        rd_check("b2b_status_clr", 8'h81, 8'h00);

        // Randomised modes, dividers, slaves and bytes
        for (int t = 0; t < 6; t++) begin
            rdiv  = int'($urandom_range(0, 3));
            rss   = int'($urandom_range(0, 7));
            rb    = 8'($urandom);
            rctrl = {1'b0, 3'(rss), 1'b0, 3'($urandom_range(0, 7))};
            wr(8'h82, 8'(rdiv));
            wr(8'h83, rctrl);
            tb_cpha = rctrl[1];
            repeat (2) @(negedge clk);
            check("rnd_sclk_idle", sclk, rctrl[0]);
            mon_reset();
            wr(8'h80, rb);
            @(negedge clk);
            check("rnd_ss_n", ss_n, exp_ss(rss));
            wait_idle("rnd_idle");
            check("rnd_edges", mon_edges, 16);
            check("rnd_half_min", iv_min, rdiv + 1);
            check("rnd_half_max", iv_max, rdiv + 1);
            check("rnd_mosi_seq", mon_seq(0), wire_order(rb, rctrl[2]));
            if (rss < NUM_SS) check("rnd_byte_time", ss_low_cycles, 18 * (rdiv + 1));
            rd_check("rnd_data", 8'h80, rb);
        end

        // Reset during bit 3 of a byte
        wr(8'h82, 8'h01);
        wr(8'h83, 8'h00);
        tb_cpha = 1'b0;
        mon_reset();
        wr(8'h80, 8'hFF);
        n = 0;
        while (mon_edges < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit3", (mon_edges >= 6), 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_ss_n", ss_n, 4'hF);
        check("abort_sclk", sclk, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_ss_n_after", ss_n, 4'hF);
        rd_check("abort_status", 8'h81, 8'h00);
        rd_check("abort_div", 8'h82, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
